// File: rtl/aes128_inv_key_sched_if.sv
// -----------------------------------------------------------------------------
// aes128_inv_key_sched_if
// Bundles the key-load request and the round-key handshake of the
// decrypt-side AES-128 key schedule.
//   key_load : 1-cycle strobe, samples key_in and (re)starts the schedule
//   key_in   : 128-bit cipher key, [127:96]=w0, byte 0 at [127:120]
//   rk_ready : consumer accepts rk_out this cycle
//   rk_valid : rk_out / rk_round valid
//   rk_out   : current round key, same word/byte order as key_in
//   rk_round : round index of rk_out (10 down to 0)
//   rk_last  : rk_valid and rk_round==0
//   busy     : schedule is expanding or serving keys
// master = key consumer / requester, slave = key schedule.
// -----------------------------------------------------------------------------
interface aes128_inv_key_sched_if;
    logic         key_load;
    logic [127:0] key_in;
    logic         rk_ready;
    logic         rk_valid;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         rk_last;
    logic         busy;

    modport master (
        output key_load, key_in, rk_ready,
        input  rk_valid, rk_out, rk_round, rk_last, busy
    );

    modport slave (
        input  key_load, key_in, rk_ready,
        output rk_valid, rk_out, rk_round, rk_last, busy
    );
endinterface

// File: rtl/aes128_inv_key_sched.sv
// -----------------------------------------------------------------------------
// aes128_inv_key_sched
// Decrypt-side round-key source for AES-128. A loaded cipher key is expanded
// forward for NR steps in a single 128-bit register to reach round key NR,
// then the schedule is walked backwards one step per accepted key, presenting
// round keys NR, NR-1, ..., 0. No 11-entry key buffer is kept.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   kif   : key-load / round-key handshake bundle (slave side)
// Parameters:
//   NR    : number of rounds, only 10 (AES-128) is supported
// -----------------------------------------------------------------------------
module aes128_inv_key_sched #(
    parameter int NR = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    aes128_inv_key_sched_if.slave        kif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_SERVE  = 2'd2
    } state_t;

    // GF(2^8) multiply by x modulo the AES polynomial
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Inverse of xtime, used to step rcon backwards
    function automatic logic [7:0] inv_xtime(input logic [7:0] x);
        logic [7:0] t;
        t = x ^ 8'h1b;
        return x[0] ? ({1'b0, t[7:1]} | 8'h80) : {1'b0, x[7:1]};
    endfunction

    // GF(2^8) multiply, shift-and-add
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end else begin
                p = p;
            end
            aa = xtime(aa);
        end
        return p;
    endfunction

    // FIPS-197 S-box: multiplicative inverse (x^254, 0 maps to 0) then affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;
    endfunction

    // SubWord(RotWord(w)); byte 0 of a word sits in its MSBs
    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    state_t         r_state;
    logic [127:0]   r_key;
    logic [7:0]     r_rcon;
    logic [3:0]     r_cnt;
    logic [3:0]     r_rk_round;
    logic           r_rk_valid;
    logic           r_rk_last;
    logic           r_busy;

    state_t         w_state_nxt;
    logic [127:0]   w_key_nxt;
    logic [7:0]     w_rcon_nxt;
    logic [3:0]     w_cnt_nxt;
    logic [3:0]     w_rk_round_nxt;
    logic           w_rk_valid_nxt;
    logic           w_rk_last_nxt;
    logic           w_busy_nxt;

    logic [31:0]    w_w0, w_w1, w_w2, w_w3;
    logic [31:0]    w_inv_w3;
    logic [31:0]    w_sub_in;
    logic [31:0]    w_t;
    logic [127:0]   w_fwd_key;
    logic [127:0]   w_inv_key;

    assign w_w0     = r_key[127:96];
    assign w_w1     = r_key[95:64];
    assign w_w2     = r_key[63:32];
    assign w_w3     = r_key[31:0];
    assign w_inv_w3 = w_w3 ^ w_w2;

    // Share the four S-box lookups: forward step uses w3, inverse step uses the recovered w3'
    always_comb begin
        w_sub_in = w_w3;
        if (r_state == ST_SERVE) begin
            w_sub_in = w_inv_w3;
        end else begin
            w_sub_in = w_w3;
        end
    end

    assign w_t = sub_rot(w_sub_in) ^ {r_rcon, 24'h000000};

    // Forward and inverse key-schedule steps built on the shared S-box result
    always_comb begin
        logic [31:0] f0, f1, f2, f3;
        f0 = w_w0 ^ w_t;
        f1 = w_w1 ^ f0;
        f2 = w_w2 ^ f1;
        f3 = w_w3 ^ f2;
        w_fwd_key = {f0, f1, f2, f3};
        w_inv_key = {w_w0 ^ w_t, w_w1 ^ w_w0, w_w2 ^ w_w1, w_inv_w3};
    end

    // Next-state and next-output logic; a key_load restarts from any state
    always_comb begin
        w_state_nxt    = r_state;
        w_key_nxt      = r_key;
        w_rcon_nxt     = r_rcon;
        w_cnt_nxt      = r_cnt;
        w_rk_round_nxt = r_rk_round;
        w_rk_valid_nxt = r_rk_valid;
        w_rk_last_nxt  = r_rk_last;
        w_busy_nxt     = r_busy;

        if (kif.key_load) begin
            w_state_nxt    = ST_EXPAND;
            w_key_nxt      = kif.key_in;
            w_rcon_nxt     = 8'h01;
            w_cnt_nxt      = 4'd0;
            w_rk_valid_nxt = 1'b0;
            w_rk_last_nxt  = 1'b0;
            w_busy_nxt     = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_IDLE;
                end
                ST_EXPAND: begin
                    w_key_nxt  = w_fwd_key;
                    w_rcon_nxt = xtime(r_rcon);
                    w_cnt_nxt  = r_cnt + 4'd1;
                    if (r_cnt == 4'(NR - 1)) begin
                        // The last forward constant is reused for the first inverse step
                        w_state_nxt    = ST_SERVE;
                        w_rk_round_nxt = 4'(NR);
                        w_rcon_nxt     = 8'h36;
                        w_rk_valid_nxt = 1'b1;
                        w_rk_last_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = ST_EXPAND;
                    end
                end
                ST_SERVE: begin
                    if (r_rk_valid && kif.rk_ready) begin
                        if (r_rk_round != 4'd0) begin
                            w_key_nxt      = w_inv_key;
                            w_rcon_nxt     = inv_xtime(r_rcon);
                            w_rk_round_nxt = r_rk_round - 4'd1;
                            w_rk_last_nxt  = (r_rk_round == 4'd1);
                        end else begin
                            w_state_nxt    = ST_IDLE;
                            w_rk_valid_nxt = 1'b0;
                            w_rk_last_nxt  = 1'b0;
                            w_busy_nxt     = 1'b0;
                        end
                    end else begin
                        w_state_nxt = ST_SERVE;
                    end
                end
                default: begin
                    w_state_nxt    = ST_IDLE;
                    w_rk_valid_nxt = 1'b0;
                    w_rk_last_nxt  = 1'b0;
                    w_busy_nxt     = 1'b0;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_key      <= 128'h0;
            r_rcon     <= 8'h01;
            r_cnt      <= 4'd0;
            r_rk_round <= 4'd0;
            r_rk_valid <= 1'b0;
            r_rk_last  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_key      <= w_key_nxt;
            r_rcon     <= w_rcon_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rk_round <= w_rk_round_nxt;
            r_rk_valid <= w_rk_valid_nxt;
            r_rk_last  <= w_rk_last_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    assign kif.rk_out   = r_key;
    assign kif.rk_round = r_rk_round;
    assign kif.rk_valid = r_rk_valid;
    assign kif.rk_last  = r_rk_last;
    assign kif.busy     = r_busy;

endmodule

// File: tb/tb_aes128_inv_key_sched.sv
// -----------------------------------------------------------------------------
// tb_aes128_inv_key_sched
// Self-checking bench: round keys come from a table-driven FIPS-197 forward
// key expansion (all 44 words), and the DUT's backward walk is compared
// against that list under steady and random rk_ready.
// -----------------------------------------------------------------------------
module tb_aes128_inv_key_sched;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    logic [127:0] exp_rk [0:10];

    aes128_inv_key_sched_if kif ();

    aes128_inv_key_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kif   (kif)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts one comparison and reports a mismatch
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Standard FIPS-197 key expansion into 44 words; fills exp_rk[0..10]
    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {SBOX[t[31:24]], SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]]} ^ {rc, 24'h000000};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Pulse key_load (called just after a clock edge); optionally measure latency to rk_valid
    task automatic load_key(input logic [127:0] key, input bit wait_valid);
        int lat;
        kif.key_in   = key;
        kif.key_load = 1'b1;
        @(posedge clk); #1;
        kif.key_load = 1'b0;
        chk("load_valid_low", 128'(kif.rk_valid), 128'd0);
        chk("load_busy", 128'(kif.busy), 128'd1);
        if (wait_valid) begin
            lat = 0;
            while (!kif.rk_valid && lat < 40) begin
                @(posedge clk); #1;
                lat++;
            end
            chk("latency", 128'(lat), 128'd10);
        end
    endtask

    // Consume keys from round 10 down, stopping once round stop_round is shown (-1 = full run)
    task automatic serve(input bit rand_rdy, input int stop_round);
        int r;
        int guard;
        bit rdy;
        r = 10;
        guard = 0;
        while (r > stop_round && guard < 300) begin
            rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            kif.rk_ready = rdy;
            chk("rk_valid", 128'(kif.rk_valid), 128'd1);
            chk("rk_out", kif.rk_out, exp_rk[r]);
            chk("rk_round", 128'(kif.rk_round), 128'(r));
            chk("rk_last", 128'(kif.rk_last), 128'(r == 0));
            @(posedge clk); #1;
            if (rdy) r--;
            guard++;
        end
        chk("serve_reached", 128'(r == stop_round), 128'd1);
        if (stop_round < 0) begin
            chk("end_valid", 128'(kif.rk_valid), 128'd0);
            chk("end_busy", 128'(kif.busy), 128'd0);
            chk("end_last", 128'(kif.rk_last), 128'd0);
        end else begin
            chk("stop_round", 128'(kif.rk_round), 128'(stop_round));
            chk("stop_valid", 128'(kif.rk_valid), 128'd1);
        end
    endtask

    // Assert rst_n asynchronously, check reset values, then confirm the block stays idle
    task automatic reset_check();
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 128'(kif.rk_valid), 128'd0);
        chk("rst_busy", 128'(kif.busy), 128'd0);
        chk("rst_last", 128'(kif.rk_last), 128'd0);
        chk("rst_out", kif.rk_out, 128'd0);
        chk("rst_round", 128'(kif.rk_round), 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_busy", 128'(kif.busy), 128'd0);
        chk("idle_valid", 128'(kif.rk_valid), 128'd0);
    endtask

    // Watchdog against a stuck simulation
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [127:0] key_a;
        logic [127:0] key_b;
        n_checks = 0;
        n_pass   = 0;
        rst_n        = 1'b0;
        kif.key_load = 1'b0;
        kif.key_in   = 128'h0;
        kif.rk_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("por_valid", 128'(kif.rk_valid), 128'd0);
        chk("por_busy", 128'(kif.busy), 128'd0);
        chk("por_out", kif.rk_out, 128'd0);
        chk("por_round", 128'(kif.rk_round), 128'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // FIPS-197 vector, steady rk_ready; the reference list itself is checked against known keys
        model_expand(FIPS_KEY);
        chk("ref_rk10", exp_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("ref_rk9", exp_rk[9], 128'hac7766f319fadc2128d12941575c006e);
        chk("ref_rk1", exp_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("ref_rk0", exp_rk[0], FIPS_KEY);
        kif.rk_ready = 1'b1;
        load_key(FIPS_KEY, 1'b1);
        serve(1'b0, -1);

        // Same key, random stalls, loaded back-to-back after the previous run
        load_key(FIPS_KEY, 1'b1);
        serve(1'b1, -1);

        // All-zero key
        model_expand(128'h0);
        chk("ref_zero_rk10", exp_rk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        load_key(128'h0, 1'b1);
        serve(1'b0, -1);

        // Random keys with random stalls
        for (int k = 0; k < 3; k++) begin
            key_a = {$urandom, $urandom, $urandom, $urandom};
            model_expand(key_a);
            load_key(key_a, 1'b1);
            serve(1'b1, -1);
        end

        // Abort at round 6 with a new key, simultaneous with a handshake
        key_a = {$urandom, $urandom, $urandom, $urandom};
        key_b = {$urandom, $urandom, $urandom, $urandom};
        model_expand(key_a);
        load_key(key_a, 1'b1);
        serve(1'b1, 6);
        model_expand(key_b);
        kif.rk_ready = 1'b1;
        load_key(key_b, 1'b1);
        serve(1'b1, -1);

        // Back-to-back: load in the cycle right after the last key was accepted
        key_a = {$urandom, $urandom, $urandom, $urandom};
        model_expand(key_a);
        load_key(key_a, 1'b1);
        serve(1'b0, -1);

        // Reset in the middle of expansion
        load_key(key_a, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        reset_check();

        // Reset in the middle of serving
        kif.rk_ready = 1'b1;
        load_key(key_a, 1'b1);
        serve(1'b0, 7);
        reset_check();

        // Recovery after reset
        key_b = {$urandom, $urandom, $urandom, $urandom};
        model_expand(key_b);
        load_key(key_b, 1'b1);
        serve(1'b1, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
